// File: rtl/mem_access_unit_if.sv
// Bundles the CPU load/store request/response channel and the Avalon-style
// data RAM master port driven by mem_access_unit.
interface mem_access_unit_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic [3:0]        req_op;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic [DATA_W-1:0] req_rt;
  logic              resp_valid;
  logic [DATA_W-1:0] resp_rdata;
  logic              resp_err;

  logic [ADDR_W-1:0] avm_address;
  logic [3:0]        avm_byteenable;
  logic              avm_read;
  logic              avm_write;
  logic [DATA_W-1:0] avm_writedata;
  logic              avm_waitrequest;
  logic [DATA_W-1:0] avm_readdata;

  modport master (
    input  req_valid, req_op, req_addr, req_wdata, req_rt,
    output req_ready, resp_valid, resp_rdata, resp_err,
    output avm_address, avm_byteenable, avm_read, avm_write, avm_writedata,
    input  avm_waitrequest, avm_readdata
  );

  modport slave (
    output req_valid, req_op, req_addr, req_wdata, req_rt,
    input  req_ready, resp_valid, resp_rdata, resp_err,
    input  avm_address, avm_byteenable, avm_read, avm_write, avm_writedata,
    output avm_waitrequest, avm_readdata
  );
endinterface

// File: rtl/mem_access_unit.sv
// Load/store bus master: one request at a time, byte-lane steering on stores,
// and alignment / sign extension / LWL-LWR merging on loads.
module mem_access_unit #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic           clk,
  input  logic           reset,
  mem_access_unit_if.master bus
);

  typedef enum logic [1:0] {IDLE, BUS, DATA, RESP} state_t;

  state_t            state_q, state_d;
  logic [3:0]        op_q;
  logic [1:0]        ofs_q;
  logic [ADDR_W-1:0] addr_q;
  logic [3:0]        be_q;
  logic [DATA_W-1:0] wdata_q, rt_q;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              store_q, err_q;
  logic              req_ready_q, resp_valid_q, avm_read_q, avm_write_q;

  logic              accept;
  logic              store_sel;
  logic [1:0]        in_ofs;
  logic              in_legal, in_misalign, in_err;
  logic [3:0]        in_be;
  logic [DATA_W-1:0] in_wdata;
  logic [DATA_W-1:0] shifted, load_data;
  logic [4:0]        rsh, lsh;

  assign accept    = bus.req_valid & req_ready_q;
  assign store_sel = (state_q == IDLE) ? bus.req_op[3] : store_q;
  assign in_ofs    = bus.req_addr[1:0];

  // Request decode: legality, alignment, byte enables and store lane replication.
  always_comb begin
    in_legal    = 1'b1;
    in_misalign = 1'b0;
    in_be       = 4'b0000;
    case (bus.req_op)
      4'b0000, 4'b0100, 4'b1000: in_be = 4'b0001 << in_ofs;
      4'b0001, 4'b0101, 4'b1001: begin
        in_be       = 4'b0011 << in_ofs;
        in_misalign = in_ofs[0];
      end
      4'b0011, 4'b1011: begin
        in_be       = 4'b1111;
        in_misalign = (in_ofs != 2'b00);
      end
      4'b0010: in_be = 4'b1111 >> (2'd3 - in_ofs);
      4'b0110: in_be = 4'b1111 << in_ofs;
      default: in_legal = 1'b0;
    endcase
    in_err = ~in_legal | in_misalign;

    in_wdata = '0;
    if (bus.req_op[3]) begin
      case (bus.req_op[1:0])
        2'b00:   in_wdata = {4{bus.req_wdata[7:0]}};
        2'b01:   in_wdata = {2{bus.req_wdata[15:0]}};
        default: in_wdata = bus.req_wdata;
      endcase
    end
  end

  // 8*(3-a) is {~a,3'b000} for a 2-bit offset.
  assign rsh     = {ofs_q, 3'b000};
  assign lsh     = {~ofs_q, 3'b000};
  assign shifted = bus.avm_readdata >> rsh;

  always_comb begin
    load_data = '0;
    case (op_q)
      4'b0000: load_data = {{24{shifted[7]}}, shifted[7:0]};
      4'b0100: load_data = {24'h0, shifted[7:0]};
      4'b0001: load_data = {{16{shifted[15]}}, shifted[15:0]};
      4'b0101: load_data = {16'h0, shifted[15:0]};
      4'b0011: load_data = bus.avm_readdata;
      4'b0010: load_data = (bus.avm_readdata << lsh) | (rt_q & ~(32'hFFFF_FFFF << lsh));
      4'b0110: load_data = shifted | (rt_q & ~(32'hFFFF_FFFF >> rsh));
      default: load_data = '0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = in_err ? RESP : BUS;
          if (in_err) rdata_d = '0;
        end
      end
      BUS: begin
        if (!bus.avm_waitrequest) begin
          state_d = store_q ? RESP : DATA;
          if (store_q) rdata_d = '0;
        end
      end
      DATA: begin
        state_d = RESP;
        rdata_d = load_data;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Handshake outputs are registered from the next state so they are all low in reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      op_q         <= '0;
      ofs_q        <= '0;
      addr_q       <= '0;
      be_q         <= '0;
      wdata_q      <= '0;
      rt_q         <= '0;
      rdata_q      <= '0;
      store_q      <= 1'b0;
      err_q        <= 1'b0;
      req_ready_q  <= 1'b0;
      resp_valid_q <= 1'b0;
      avm_read_q   <= 1'b0;
      avm_write_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rdata_q <= rdata_d;
      if (accept) begin
        op_q    <= bus.req_op;
        ofs_q   <= in_ofs;
        addr_q  <= {bus.req_addr[ADDR_W-1:2], 2'b00};
        be_q    <= in_be;
        wdata_q <= in_wdata;
        rt_q    <= bus.req_rt;
        store_q <= bus.req_op[3];
        err_q   <= in_err;
      end
      req_ready_q  <= (state_d == IDLE);
      resp_valid_q <= (state_d == RESP);
      avm_read_q   <= (state_d == BUS) & ~store_sel;
      avm_write_q  <= (state_d == BUS) & store_sel;
    end
  end

  assign bus.req_ready      = req_ready_q;
  assign bus.resp_valid     = resp_valid_q;
  assign bus.resp_err       = resp_valid_q & err_q;
  assign bus.resp_rdata     = rdata_q;
  assign bus.avm_address    = addr_q;
  assign bus.avm_byteenable = be_q;
  assign bus.avm_read       = avm_read_q;
  assign bus.avm_write      = avm_write_q;
  assign bus.avm_writedata  = wdata_q;

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
CPU-side bus master between the MIPS datapath's load/store stage and the data RAM's Avalon-style slave port (address, byteenable, read, write, writedata, waitrequest, readdata).
- Accepts one load/store request at a time and computes the byte enables.
- Replicates store data onto the correct lanes and honours waitrequest.
- Captures read data one cycle after the read is accepted, then aligns and sign/zero-extends it (incl. LWL/LWR merge) before returning it to the CPU.

Parameters:
ADDR_W, 32, byte address width on both sides
DATA_W, 32, data width; fixed at 32, other values unsupported

Ports:
clk  in  1  single clock, all state on posedge
reset  in  1  synchronous, active-high
req_valid  in  1  CPU request strobe
req_ready  out  1  unit can accept a request (IDLE only)
req_op  in  4  MIPS opcode[3:0]: 0000 LB, 0001 LH, 0010 LWL, 0011 LW, 0100 LBU, 0101 LHU, 0110 LWR, 1000 SB, 1001 SH, 1011 SW; all others illegal
req_addr  in  32  byte address
req_wdata  in  32  store data (rt)
req_rt  in  32  current rt value, merge source for LWL/LWR
resp_valid  out  1  one-cycle completion pulse
resp_rdata  out  32  load result, 0 for stores/errors
resp_err  out  1  misaligned or illegal op, valid with resp_valid
avm_address  out  32  {req_addr[31:2],2'b00}
avm_byteenable  out  4  bit i enables lane i = bits[8i+7:8i] (little-endian)
avm_read  out  1  read request
avm_write  out  1  write request
avm_writedata  out  32  lane-replicated store data
avm_waitrequest  in  1  slave stall; request held while high
avm_readdata  in  32  valid the cycle after a read is accepted

Behaviour:
Reset:
- state=IDLE; req_ready, resp_valid, resp_err, avm_read, avm_write = 0.
- avm_byteenable, avm_address, avm_writedata, resp_rdata = 0.
- Reset mid-transaction abandons it; avm_read/avm_write low the next cycle; no resp_valid is produced.

Byte offset a=req_addr[1:0]; all request fields are registered on acceptance (req_valid & req_ready at posedge).

FSM states: IDLE, BUS, DATA, RESP.
- IDLE: req_ready=1.
  - Legal and aligned request -> BUS.
  - Illegal or misaligned request -> RESP with resp_err=1; no bus cycle is issued.
- BUS: avm_read or avm_write=1; address, byteenable and writedata held stable.
  - avm_waitrequest=1 at posedge: stay in BUS.
  - Otherwise: load -> DATA; store -> RESP.
- DATA: sample avm_readdata; compute resp_rdata -> RESP.
- RESP: resp_valid=1 for exactly one cycle -> IDLE. req_ready=0, so back-to-back requests are not accepted in the RESP cycle.

Latency (no wait states), counted from the acceptance edge:
- Loads: resp_valid in the 3rd cycle.
- Stores: resp_valid in the 2nd cycle.
- Errors: resp_valid in the 1st cycle.
- Each waitrequest cycle adds 1.

Byte enables:
- LB/LBU/SB: 1<<a.
- LH/LHU/SH: 0011<<a; requires a[0]=0.
- LW/SW: 1111; requires a=0.
- LWL: lanes 0..a set.
- LWR: lanes a..3 set.
- LWL/LWR never misalign.

Store data:
- SB: {4{wdata[7:0]}}.
- SH: {2{wdata[15:0]}}.
- SW: wdata.

Load data, with lane L = readdata[8a+7:8a]:
- LB: sign-extend L; LBU: zero-extend L.
- LH/LHU: sign/zero-extend readdata[8a+15:8a].
- LW: readdata.
- LWL: (readdata << 8*(3-a)) | (rt & ((1<<8*(3-a))-1)).
- LWR: (readdata >> 8a) | (rt & ~(32'hFFFFFFFF >> 8a)).

Other rules:
- req_valid outside IDLE is ignored.
- resp_rdata holds its value until the next resp_valid.
- avm_read and avm_write are never both high.

Test Plan:
1. Word 0x100 = 0x8899AABB. LB 0x101 -> be=0010, resp_rdata=0xFFFFFFAA. LBU 0x101 -> 0x000000AA, resp_valid 3 cycles after acceptance.
2. LH 0x102 -> be=1100, resp_rdata=0xFFFF8899. LHU 0x102 -> 0x00008899. LW 0x100 -> 0x8899AABB.
3. rt=0x11223344. LWL 0x101 -> be=0011, resp_rdata=0xAABB3344. LWR 0x101 -> be=1110, resp_rdata=0x118899AA.
4. SB 0x103, wdata=0x000000CC -> avm_write=1, be=1000, writedata=0xCCCCCCCC, address=0x100. Readback LW 0x100 -> 0xCC99AABB.
5. LW 0x102 or SH 0x101 -> resp_err=1, resp_valid 1 cycle after acceptance, avm_read and avm_write never asserted. Opcode 0111 behaves the same way.
6. waitrequest held high for 3 cycles during LW -> address and be stable throughout, resp_valid delayed by exactly 3 cycles. Reset asserted while in BUS -> avm_read=0 next cycle, no resp_valid, req_ready=1 after reset deasserts.
